score_player: RTL and testbench

SCORE_PLAYER -- requirements
Module: score_player

---
 rtl/score_player_pkg.sv | 41 ++++
 rtl/score_player.sv | 126 ++++++++++++
 tb/tb_score_player.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_player_pkg.sv
// Shared definitions for the score player: command word layout, reserved
// command values, word classification and the playback state encoding.
package score_player_pkg;

    localparam int CMD_W         = 12;
    localparam int CMD_DELAY_BIT = 11;
    localparam int CMD_NOTE_BIT  = 10;

    localparam logic [CMD_W-1:0] CMD_STOP = 12'h000;
    localparam logic [CMD_W-1:0] CMD_END  = 12'h800;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        K_STOP,
        K_NOTE,
        K_DELAY,
        K_END
    } cmd_kind_e;

    // A zero-length delay is reserved as the end-of-score marker.
    function automatic cmd_kind_e cmd_kind(input logic [CMD_W-1:0] w);
        if (w == CMD_END) begin
            return K_END;
        end else if (w[CMD_DELAY_BIT]) begin
            return K_DELAY;
        end else if (w[CMD_NOTE_BIT]) begin
            return K_NOTE;
        end else begin
            return K_STOP;
        end
    endfunction

endpackage

// File: rtl/score_player.sv
// Walks a score held in an external synchronous memory and forwards note,
// stop and delay words to the note sequencer, pacing delays on busy.
module score_player
    import score_player_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CMD_W-1:0]  rom_data,
    output logic [CMD_W-1:0]  command,
    input  logic              busy,
    output logic              playing,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CMD_W-1:0]   word_q, word_d;
    logic [CMD_W-1:0]   command_q, command_d;
    logic               done_q, done_d;
    logic               end_q, end_d;
    logic               advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= FIRST_ADDR;
            word_q    <= CMD_STOP;
            command_q <= CMD_STOP;
            done_q    <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            command_q <= command_d;
            done_q    <= done_d;
            end_q     <= end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        command_d = command_q;
        done_d    = 1'b0;
        end_d     = end_q;
        advance   = 1'b0;

        if (stop && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            addr_d    = FIRST_ADDR;
            command_d = CMD_STOP;
            end_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d    = FIRST_ADDR;
                    command_d = CMD_STOP;
                    end_d     = 1'b0;
                    if (start && !stop) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_LATCH;
                ST_LATCH: begin
                    word_d  = rom_data;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    // end_q marks that the last address has been played out.
                    if (end_q || cmd_kind(word_q) == K_END) begin
                        addr_d = FIRST_ADDR;
                        end_d  = 1'b0;
                        if (loop) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d   = ST_IDLE;
                            command_d = CMD_STOP;
                            done_d    = 1'b1;
                        end
                    end else if (cmd_kind(word_q) == K_DELAY) begin
                        command_d = word_q;
                        state_d   = ST_ARM;
                    end else begin
                        command_d = word_q;
                        advance   = 1'b1;
                    end
                end
                ST_ARM: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (!busy) begin
                        advance = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Stepping past the top address ends the score instead of wrapping.
            if (advance) begin
                state_d = ST_FETCH;
                if (addr_q == LAST_ADDR) begin
                    end_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign rom_addr = addr_q;
    assign command  = command_q;
    assign playing  = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_score_player.sv
// Bench for score_player: behavioural playback model checked every cycle,
// directed scenarios with literal expectations, then randomized scores.
module tb_score_player;

  localparam int ADDR_W = 2;
  localparam int START_ADDR = 0;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop = 1'b0;
  logic busy = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [11:0] command;
  logic playing;
  logic done;

  logic [11:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  score_player #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .loop(loop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .command(command),
    .busy(busy),
    .playing(playing),
    .done(done)
  );

  // ---------------- behavioural model ----------------
  // The score is read as a program: each word costs three cycles, a delay
  // adds one guard cycle then waits for busy low, the end marker (or running
  // off the top of memory) either restarts or finishes.
  bit m_active;
  int m_pc;
  int m_k;
  bit m_wait;
  bit m_guard;
  bit m_past;
  logic [11:0] m_cmd;
  bit m_done;
  int m_delay_cnt = 0;

  task automatic model_reset();
    m_active = 0; m_pc = START_ADDR; m_k = 0; m_wait = 0; m_guard = 0;
    m_past = 0; m_cmd = 12'h000; m_done = 0;
  endtask

  task automatic next_word();
    if (m_pc == DEPTH - 1) m_past = 1;
    else m_pc = m_pc + 1;
    m_k = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic lp, input logic b);
    logic [11:0] w;
    m_done = 0;
    if (!m_active) begin
      if (s && !p) begin
        m_active = 1; m_k = 0; m_wait = 0; m_guard = 0; m_past = 0; m_pc = START_ADDR;
      end
    end else if (p) begin
      m_active = 0; m_cmd = 12'h000; m_pc = START_ADDR; m_wait = 0; m_past = 0;
    end else if (m_wait) begin
      if (m_guard) m_guard = 0;
      else if (!b) begin
        m_wait = 0;
        next_word();
      end
    end else if (m_k < 2) begin
      m_k = m_k + 1;
    end else begin
      w = m_past ? 12'h800 : mem[m_pc];
      if (w == 12'h800) begin
        m_pc = START_ADDR; m_past = 0; m_k = 0;
        if (!lp) begin
          m_active = 0; m_cmd = 12'h000; m_done = 1;
        end
      end else begin
        m_cmd = w;
        if (w[11]) begin
          m_wait = 1; m_guard = 1; m_delay_cnt = m_delay_cnt + 1;
        end else begin
          next_word();
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(start, stop, loop, busy);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("command", 32'(command), 32'(m_cmd));
      check("rom_addr", 32'(rom_addr), m_active ? m_pc : START_ADDR);
      check("playing", 32'(playing), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
    end
  end

  // Scoreboard for directed scenarios: distinct command values as they appear.
  logic [11:0] exp_q[$];
  logic [11:0] seen_q[$];
  logic [11:0] last_cmd;
  int done_cnt;
  bit wrap_seen;
  logic [ADDR_W-1:0] prev_addr;
  bit prev_playing;

  always @(negedge clk) begin
    if (rst_n) begin
      if (command !== last_cmd) seen_q.push_back(command);
      last_cmd = command;
      if (done === 1'b1) done_cnt++;
      if (playing && prev_playing && prev_addr != 0 && rom_addr == 0) wrap_seen = 1;
      prev_addr = rom_addr;
      prev_playing = playing;
    end
  end

  task automatic clear_mon();
    seen_q.delete();
    exp_q.delete();
    last_cmd = command;
    done_cnt = 0;
    wrap_seen = 0;
    prev_addr = rom_addr;
    prev_playing = playing;
  endtask

  task automatic cmp_seq(input string name, input bit exact);
    if (exact) check({name, "_len"}, seen_q.size(), exp_q.size());
    foreach (exp_q[i])
      check(name, (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] w0, input logic [11:0] w1,
                      input logic [11:0] w2, input logic [11:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: fixed length; 1: until playback ends; 2: until waiting with busy high.
  task automatic run(input int max_cyc, input int busy_len, input int mode);
    int dseen;
    int bleft;
    bit hit;
    dseen = m_delay_cnt;
    bleft = 0;
    hit = 0;
    for (int c = 0; c < max_cyc && !hit; c++) begin
      tick();
      if (m_delay_cnt != dseen) begin
        dseen = m_delay_cnt;
        bleft = busy_len;
      end
      busy = (bleft > 0);
      if (bleft > 0) bleft--;
      if (mode == 1 && !m_active) hit = 1;
      if (mode == 2 && m_active && m_wait && !m_guard && busy) hit = 1;
    end
    if (mode != 0) check("run_reached_target", 32'(hit), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    load(12'h000, 12'h000, 12'h000, 12'h000);
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_command", 32'(command), 32'h000);
    check("reset_rom_addr", 32'(rom_addr), START_ADDR);
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Score with a delay and explicit end, no loop.
    load(12'h445, 12'h80A, 12'h000, 12'h800);
    loop = 1'b0;
    clear_mon();
    pulse_start();
    run(200, 10, 1);
    busy = 1'b0;
    tick();
    exp_q = '{12'h445, 12'h80A, 12'h000};
    cmp_seq("seq_basic", 1);
    check("basic_done_count", done_cnt, 1);
    check("basic_playing_end", 32'(playing), 32'd0);

    // Same score looping: back to the first note, never done.
    loop = 1'b1;
    clear_mon();
    pulse_start();
    run(60, 10, 0);
    exp_q = '{12'h445, 12'h80A, 12'h000, 12'h445};
    cmp_seq("seq_loop", 0);
    check("loop_done_count", done_cnt, 0);
    check("loop_playing", 32'(playing), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    busy = 1'b0;
    tick();
    check("loop_stopped", 32'(playing), 32'd0);

    // Stop while waiting on the delay word.
    loop = 1'b0;
    clear_mon();
    pulse_start();
    run(100, 10, 2);
    check("wait_cmd_held", 32'(command), 32'h80A);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_command", 32'(command), 32'h000);
    check("stop_playing", 32'(playing), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    busy = 1'b0;
    tick();
    check("stop_no_done", done_cnt, 0);

    // Asynchronous reset in the middle of a wait.
    pulse_start();
    run(100, 10, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_command", 32'(command), 32'h000);
    check("async_rst_rom_addr", 32'(rom_addr), START_ADDR);
    check("async_rst_playing", 32'(playing), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", 32'(playing), 32'd0);

    // No end marker: running off the top address ends the score.
    load(12'h401, 12'h402, 12'h403, 12'h404);
    clear_mon();
    pulse_start();
    run(100, 0, 1);
    tick();
    exp_q = '{12'h401, 12'h402, 12'h403, 12'h404, 12'h000};
    cmp_seq("seq_top", 1);
    check("top_done_count", done_cnt, 1);
    check("top_no_wrap", 32'(wrap_seen), 32'd0);

    // start and stop together from idle.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    check("start_stop_idle", 32'(playing), 32'd0);
    check("start_stop_cmd", 32'(command), 32'h000);

    // Randomized scores, interruptions and busy behaviour.
    for (int ep = 0; ep < 40; ep++) begin
      int dseen;
      int bleft;
      int blen;
      int ncyc;
      for (int i = 0; i < DEPTH; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) mem[i] = 12'h400 | 12'($urandom_range(0, 1023));
        else if (r < 7) mem[i] = 12'($urandom_range(0, 12'h3FF));
        else if (r < 9) mem[i] = 12'h800 | 12'($urandom_range(1, 2047));
        else mem[i] = 12'h800;
      end
      loop = 1'($urandom_range(0, 1));
      blen = $urandom_range(0, 6);
      ncyc = $urandom_range(30, 120);
      dseen = m_delay_cnt;
      bleft = 0;
      pulse_start();
      for (int c = 0; c < ncyc; c++) begin
        tick();
        if (m_delay_cnt != dseen) begin
          dseen = m_delay_cnt;
          bleft = blen;
        end
        busy = (bleft > 0) || ($urandom_range(0, 7) == 0);
        if (bleft > 0) bleft--;
        start = ($urandom_range(0, 15) == 0);
        stop = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 31) == 0) loop = ~loop;
      end
      start = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      busy = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
